// File: rtl/dsp_fetch_pkg.sv
// dsp_fetch_pkg: default widths and the prefetch entry layout shared by the fetch unit
package dsp_fetch_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_INST_W = 32;
  localparam int DEF_PF_DEPTH = 4;
  localparam int DEF_CNT_W = 16;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/dsp_fetch_loop_if.sv
// dsp_fetch_loop_if: memory bus, decode handshake and loop/jump controls of the fetch unit
interface dsp_fetch_loop_if
  import dsp_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INST_W = DEF_INST_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [INST_W-1:0] mem_data;
  logic              jump_flag;
  logic [ADDR_W-1:0] jump_addr;
  logic              loop_load;
  logic [ADDR_W-1:0] loop_start;
  logic [ADDR_W-1:0] loop_end;
  logic [CNT_W-1:0]  loop_count;
  logic              inst_valid;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic              loop_active;
  modport master (
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc, loop_active,
    input  mem_data, jump_flag, jump_addr, loop_load, loop_start, loop_end, loop_count, inst_ready
  );
  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc, loop_active,
    output mem_data, jump_flag, jump_addr, loop_load, loop_start, loop_end, loop_count, inst_ready
  );
endinterface

// File: rtl/dsp_prefetch_fifo.sv
// dsp_prefetch_fifo: first-word-fall-through prefetch buffer with flush and occupancy output
module dsp_prefetch_fifo
  import dsp_fetch_pkg::*;
#(
  parameter type T = fetch_entry_t,
  parameter int DEPTH = DEF_PF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  T            din,
  output T            dout,
  output logic [AW:0] occ
);
  T mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] occ_q, occ_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop & (occ_q != '0);
    do_push = push & ((occ_q != (AW+1)'(DEPTH)) | do_pop);
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    occ_d = flush ? '0 : occ_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // storage is reset too so the decode-facing fields read zero out of reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      occ_q <= occ_d;
      if (do_push && !flush) mem_q[wr_q] <= din;
    end
  assign dout = mem_q[rd_q];
  assign occ = occ_q;
endmodule

// File: rtl/dsp_fetch_loop.sv
// dsp_fetch_loop: credit-based instruction fetch with prefetch FIFO, jump flush
// and one zero-overhead hardware loop
module dsp_fetch_loop
  import dsp_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INST_W = DEF_INST_W,
  parameter int PF_DEPTH = DEF_PF_DEPTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input logic clk,
  input logic rst,
  dsp_fetch_loop_if.master bus
);
  localparam int AW = $clog2(PF_DEPTH);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;
  logic [ADDR_W-1:0] pc_q, pc_d, tag_q, tag_d, ls_q, ls_d, le_q, le_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic infl_q, act_q, act_d, req, pop, push, at_end;
  logic [AW:0] occ;
  logic [AW+1:0] credit;
  entry_t head, din;
  always_comb begin
    pop = (occ != '0) & bus.inst_ready;
    // a jump kills the response returning this cycle; nothing else can be in flight
    push = infl_q & ~bus.jump_flag;
    credit = (AW+2)'(occ) + (AW+2)'(infl_q) - (AW+2)'(pop);
    req = rst & ~bus.jump_flag & (credit < (AW+2)'(PF_DEPTH));
    at_end = act_q & (pc_q == le_q);
    din = '{pc: tag_q, inst: bus.mem_data};
    tag_d = req ? pc_q : tag_q;
    pc_d = bus.jump_flag ? bus.jump_addr :
           !req ? pc_q :
           (at_end & (rem_q > CNT_W'(1))) ? ls_q : pc_q + ADDR_W'(1);
    rem_d = bus.loop_load ? bus.loop_count : (req & at_end) ? rem_q - CNT_W'(1) : rem_q;
    act_d = bus.loop_load ? (bus.loop_count >= CNT_W'(2)) :
            (bus.jump_flag | (req & at_end & (rem_q == CNT_W'(1)))) ? 1'b0 : act_q;
    ls_d = bus.loop_load ? bus.loop_start : ls_q;
    le_d = bus.loop_load ? bus.loop_end : le_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_q <= RESET_PC;
      tag_q <= '0;
      infl_q <= 1'b0;
      act_q <= 1'b0;
      rem_q <= '0;
      ls_q <= '0;
      le_q <= '0;
    end else begin
      pc_q <= pc_d;
      tag_q <= tag_d;
      infl_q <= req;
      act_q <= act_d;
      rem_q <= rem_d;
      ls_q <= ls_d;
      le_q <= le_d;
    end
  dsp_prefetch_fifo #(.T(entry_t), .DEPTH(PF_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(bus.jump_flag),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(head),
    .occ(occ)
  );
  assign bus.mem_req = req;
  assign bus.mem_addr = pc_q;
  assign bus.inst_valid = occ != '0;
  assign bus.inst_data = head.inst;
  assign bus.inst_pc = head.pc;
  assign bus.loop_active = act_q;
endmodule

// File: tb/tb_dsp_fetch_loop.sv
// tb_dsp_fetch_loop: scenario tasks against a program-order model of the fetched stream
module tb_dsp_fetch_loop;
  logic clk, rst;
  int n_cmp, n_err;
  typedef struct packed { logic [15:0] pc; logic [31:0] d; } obs_t;
  obs_t got[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_next;

  dsp_fetch_loop_if #(.ADDR_W(16), .INST_W(32), .CNT_W(16)) bus ();
  dsp_fetch_loop #(.ADDR_W(16), .INST_W(32), .PF_DEPTH(4), .CNT_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .bus(bus.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data(logic [15:0] a);
    return {a ^ 16'hA5C3, a};
  endfunction

  always @(posedge clk) bus.mem_data <= bus.mem_req ? exp_data(bus.mem_addr) : 32'hDEAD_BEEF;

  // the stream decode should see: a queued loop unroll, then linear addresses
  function automatic logic [15:0] model_next();
    logic [15:0] p;
    if (exp_q.size() != 0) p = exp_q.pop_front();
    else begin
      p = m_next;
      m_next = m_next + 16'd1;
    end
    return p;
  endfunction

  function automatic void model_jump(logic [15:0] a, logic ld, logic [15:0] le, logic [15:0] cnt);
    logic [15:0] k;
    exp_q.delete();
    m_next = a;
    if (ld) begin
      k = le - a;
      for (int r = 0; r < ((cnt > 16'd1) ? int'(cnt) : 1); r++)
        for (int j = 0; j <= int'(k); j++) exp_q.push_back(a + 16'(j));
      m_next = le + 16'd1;
    end
  endfunction

  task automatic tick();
    #1;
    if (bus.inst_valid && bus.inst_ready && !bus.jump_flag) got.push_back({bus.inst_pc, bus.inst_data});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.loop_active !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: req=%b valid=%b lact=%b, expected 0 0 0", bus.mem_req, bus.inst_valid, bus.loop_active);
    end
    n_cmp++;
    if (bus.mem_addr !== 16'h0 || bus.inst_pc !== 16'h0 || bus.inst_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: addr=%h pc=%h data=%h, expected zeros", bus.mem_addr, bus.inst_pc, bus.inst_data);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold_req: req=%b, expected 0", bus.mem_req);
    end
  endtask

  task automatic test_stream();
    logic [15:0] e;
    rst = 1'b1;
    bus.inst_ready = 1'b1;
    model_jump(16'h0, 1'b0, 16'h0, 16'h0);
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0) begin
      n_err++;
      $display("FAIL stream_first_req: req=%b addr=%h, expected 1 0000", bus.mem_req, bus.mem_addr);
    end
    tick();
    n_cmp++;
    if (bus.inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_latency_t1: valid=%b, expected 0", bus.inst_valid);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (bus.inst_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stream_bubble[%0d]: valid=%b, expected 1", i, bus.inst_valid);
      end
      tick();
    end
    n_cmp++;
    if (got.size() != 20) begin
      n_err++;
      $display("FAIL stream_count: got %0d, expected 20", got.size());
    end
    foreach (got[k]) begin
      e = model_next();
      n_cmp++;
      if (got[k].pc !== e || got[k].d !== exp_data(e)) begin
        n_err++;
        $display("FAIL stream_seq[%0d]: pc=%h data=%h, expected pc=%h data=%h", k, got[k].pc, got[k].d, e, exp_data(e));
      end
    end
    got.delete();
  endtask

  task automatic test_backpressure();
    logic [15:0] hp, e;
    logic [31:0] hd;
    bus.inst_ready = 1'b0;
    #1;
    hp = bus.inst_pc;
    hd = bus.inst_data;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== hp || bus.inst_data !== hd) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: valid=%b pc=%h data=%h, expected 1 %h %h", i, bus.inst_valid, bus.inst_pc, bus.inst_data, hp, hd);
      end
      if (i >= 4) begin
        n_cmp++;
        if (bus.mem_req !== 1'b0) begin
          n_err++;
          $display("FAIL bp_credit[%0d]: req=%b, expected 0", i, bus.mem_req);
        end
      end
      tick();
    end
    bus.inst_ready = 1'b1;
    repeat (12) tick();
    foreach (got[k]) begin
      e = model_next();
      n_cmp++;
      if (got[k].pc !== e || got[k].d !== exp_data(e)) begin
        n_err++;
        $display("FAIL bp_seq[%0d]: pc=%h data=%h, expected pc=%h data=%h", k, got[k].pc, got[k].d, e, exp_data(e));
      end
    end
    got.delete();
  endtask

  task automatic test_jump();
    logic [15:0] e;
    repeat (5) tick();
    bus.jump_flag = 1'b1;
    bus.jump_addr = 16'h0100;
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL jump_req_cycle: req=%b, expected 0", bus.mem_req);
    end
    tick();
    bus.jump_flag = 1'b0;
    foreach (got[k]) begin
      e = model_next();
      n_cmp++;
      if (got[k].pc !== e || got[k].d !== exp_data(e)) begin
        n_err++;
        $display("FAIL jump_pre_seq[%0d]: pc=%h data=%h, expected pc=%h data=%h", k, got[k].pc, got[k].d, e, exp_data(e));
      end
    end
    got.delete();
    model_jump(16'h0100, 1'b0, 16'h0, 16'h0);
    #1;
    n_cmp++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0100) begin
      n_err++;
      $display("FAIL jump_t1: valid=%b req=%b addr=%h, expected 0 1 0100", bus.inst_valid, bus.mem_req, bus.mem_addr);
    end
    tick();
    n_cmp++;
    if (bus.inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL jump_t2: valid=%b, expected 0", bus.inst_valid);
    end
    tick();
    n_cmp++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0100) begin
      n_err++;
      $display("FAIL jump_t3: valid=%b pc=%h, expected 1 0100", bus.inst_valid, bus.inst_pc);
    end
    repeat (8) tick();
    foreach (got[k]) begin
      e = model_next();
      n_cmp++;
      if (got[k].pc !== e || got[k].d !== exp_data(e)) begin
        n_err++;
        $display("FAIL jump_seq[%0d]: pc=%h data=%h, expected pc=%h data=%h", k, got[k].pc, got[k].d, e, exp_data(e));
      end
    end
    got.delete();
  endtask

  task automatic jump_load(logic [15:0] a, logic ld, logic [15:0] le, logic [15:0] cnt);
    bus.jump_flag = 1'b1;
    bus.jump_addr = a;
    bus.loop_load = ld;
    bus.loop_start = a;
    bus.loop_end = le;
    bus.loop_count = cnt;
    tick();
    bus.jump_flag = 1'b0;
    bus.loop_load = 1'b0;
    got.delete();
    model_jump(a, ld, le, cnt);
  endtask

  task automatic test_loop();
    logic [15:0] e;
    int n12;
    jump_load(16'h0010, 1'b1, 16'h0012, 16'd3);
    n12 = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_cmp++;
      if (bus.loop_active !== (n12 < 3)) begin
        n_err++;
        $display("FAIL loop_active[%0d]: lact=%b, expected %b", i, bus.loop_active, n12 < 3);
      end
      if (i >= 2) begin
        n_cmp++;
        if (bus.inst_valid !== 1'b1) begin
          n_err++;
          $display("FAIL loop_bubble[%0d]: valid=%b, expected 1", i, bus.inst_valid);
        end
      end
      if (bus.mem_req === 1'b1 && bus.mem_addr === 16'h0012) n12++;
      tick();
    end
    foreach (got[k]) begin
      e = model_next();
      n_cmp++;
      if (got[k].pc !== e || got[k].d !== exp_data(e)) begin
        n_err++;
        $display("FAIL loop_seq[%0d]: pc=%h data=%h, expected pc=%h data=%h", k, got[k].pc, got[k].d, e, exp_data(e));
      end
    end
    got.delete();
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    jump_load(16'hFFFD, 1'b0, 16'h0, 16'h0);
    repeat (10) tick();
    foreach (got[k]) begin
      e = model_next();
      n_cmp++;
      if (got[k].pc !== e || got[k].d !== exp_data(e)) begin
        n_err++;
        $display("FAIL wrap_seq[%0d]: pc=%h data=%h, expected pc=%h data=%h", k, got[k].pc, got[k].d, e, exp_data(e));
      end
    end
    got.delete();
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    jump_load(16'h0040, 1'b1, 16'h0042, 16'd50);
    repeat (6) tick();
    bus.inst_ready = 1'b0;
    repeat (6) tick();
    foreach (got[k]) begin
      e = model_next();
      n_cmp++;
      if (got[k].pc !== e || got[k].d !== exp_data(e)) begin
        n_err++;
        $display("FAIL rstmid_pre_seq[%0d]: pc=%h data=%h, expected pc=%h data=%h", k, got[k].pc, got[k].d, e, exp_data(e));
      end
    end
    got.delete();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.loop_active !== 1'b0 || bus.mem_addr !== 16'h0 ||
        bus.inst_pc !== 16'h0 || bus.inst_data !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_async: req=%b valid=%b lact=%b addr=%h pc=%h data=%h, expected all zero",
               bus.mem_req, bus.inst_valid, bus.loop_active, bus.mem_addr, bus.inst_pc, bus.inst_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.inst_ready = 1'b1;
    model_jump(16'h0, 1'b0, 16'h0, 16'h0);
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0) begin
      n_err++;
      $display("FAIL rstmid_restart: req=%b addr=%h, expected 1 0000", bus.mem_req, bus.mem_addr);
    end
    repeat (12) tick();
    n_cmp++;
    if (got.size() != 10) begin
      n_err++;
      $display("FAIL rstmid_count: got %0d, expected 10", got.size());
    end
    foreach (got[k]) begin
      e = model_next();
      n_cmp++;
      if (got[k].pc !== e || got[k].d !== exp_data(e)) begin
        n_err++;
        $display("FAIL rstmid_seq[%0d]: pc=%h data=%h, expected pc=%h data=%h", k, got[k].pc, got[k].d, e, exp_data(e));
      end
    end
    got.delete();
  endtask

  task automatic test_random();
    logic hold, j;
    logic [15:0] hp, a, e;
    logic [31:0] hd;
    hold = 1'b0;
    hp = '0;
    hd = '0;
    for (int i = 0; i < 400; i++) begin
      bus.inst_ready = ($urandom_range(3) != 0);
      j = ($urandom_range(19) == 0);
      a = 16'($urandom);
      bus.jump_flag = j;
      bus.loop_load = j && ($urandom_range(1) != 0);
      bus.jump_addr = a;
      bus.loop_start = a;
      bus.loop_end = a + 16'($urandom_range(3));
      bus.loop_count = 16'($urandom_range(4));
      #1;
      if (hold) begin
        n_cmp++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== hp || bus.inst_data !== hd) begin
          n_err++;
          $display("FAIL rand_hold[%0d]: valid=%b pc=%h data=%h, expected 1 %h %h", i, bus.inst_valid, bus.inst_pc, bus.inst_data, hp, hd);
        end
      end
      hold = bus.inst_valid && !bus.inst_ready && !j;
      hp = bus.inst_pc;
      hd = bus.inst_data;
      if (bus.inst_valid && bus.inst_ready && !j) begin
        e = model_next();
        n_cmp++;
        if (bus.inst_pc !== e || bus.inst_data !== exp_data(e)) begin
          n_err++;
          $display("FAIL rand_seq[%0d]: pc=%h data=%h, expected pc=%h data=%h", i, bus.inst_pc, bus.inst_data, e, exp_data(e));
        end
      end
      @(posedge clk);
      #1;
      if (j) model_jump(a, bus.loop_load, bus.loop_end, bus.loop_count);
    end
    bus.jump_flag = 1'b0;
    bus.loop_load = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    m_next = '0;
    bus.jump_flag = 1'b0;
    bus.jump_addr = '0;
    bus.loop_load = 1'b0;
    bus.loop_start = '0;
    bus.loop_end = '0;
    bus.loop_count = '0;
    bus.inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_loop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
